// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader.
// Optional checksum trailer is enabled with BOOT_LOADER_CHECKSUM_EN.
package boot_pkg;

    typedef enum logic [2:0] {
        StHdr,
        StData,
        StWrite,
        StChk,
        StDone,
        StErr
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_BYTES      = 4;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian shift register: first byte lands in the MSBs. word_o already includes the
// byte being shifted this cycle so the caller can act on a complete word immediately.
module byte_assembler
    import boot_pkg::*;
#(
    parameter int unsigned NumBytes = BYTES_PER_WORD
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  shift_en_i,
    input  logic [7:0]            byte_i,
    output logic [NumBytes*8-1:0] word_o,
    output logic                  word_ready_o
);

    localparam int unsigned CntW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam int unsigned WordW = NumBytes * 8;

    logic [WordW-1:0] word_q, word_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d       = word_q;
        cnt_d        = cnt_q;
        word_ready_o = 1'b0;
        if (shift_en_i) begin
            word_d       = {word_q[WordW-9:0], byte_i};
            word_ready_o = (cnt_q == CntW'(NumBytes - 1));
            cnt_d        = word_ready_o ? '0 : cnt_q + CntW'(1);
        end
    end

    assign word_o = word_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed big-endian word image into memory, holding the CPU in reset.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_e EndSt = StChk;
`else
    localparam state_e EndSt = StDone;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] word_cnt_q, word_cnt_d;
    logic            transfer, hdr_shift, data_shift, hdr_ready, data_ready;
    logic [31:0]     count, data_word;

    assign transfer   = rx_valid & rx_ready;
    assign hdr_shift  = transfer & (state_q == StHdr);
    assign data_shift = transfer & (state_q == StData);

    // The header register stops shifting after its 4th byte, so it keeps the count.
    byte_assembler #(.NumBytes(HDR_BYTES)) u_hdr (
        .clk_i       (clk),
        .rst_i       (reset),
        .shift_en_i  (hdr_shift),
        .byte_i      (rx_data),
        .word_o      (count),
        .word_ready_o(hdr_ready)
    );

    byte_assembler #(.NumBytes(BYTES_PER_WORD)) u_data (
        .clk_i       (clk),
        .rst_i       (reset),
        .shift_en_i  (data_shift),
        .byte_i      (rx_data),
        .word_o      (data_word),
        .word_ready_o(data_ready)
    );

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (hdr_shift || data_shift) begin
            csum_d = csum_q ^ rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            StHdr: begin
                if (hdr_ready) begin
                    if (count == 32'd0) begin
                        state_d = EndSt;
                    end else if (count > 32'(MAX_WORDS)) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (data_ready) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                word_cnt_d = word_cnt_q + CntW'(1);
                state_d    = (32'(word_cnt_d) == count) ? EndSt : StData;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            StChk: begin
                if (transfer) begin
                    state_d = (rx_data == csum_q) ? StDone : StErr;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StHdr;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // rx_ready is gated by reset so it reads 0 while reset is held, even though state is HDR.
    assign rx_ready  = ~reset & ((state_q == StHdr) || (state_q == StData) || (state_q == StChk));
    assign mem_we    = (state_q == StWrite);
    assign mem_addr  = BASE_ADDR + (32'(word_cnt_q) << 2);
    assign mem_wdata = data_word;
    assign cpu_reset = (state_q != StDone);
    assign done      = (state_q == StDone);
    assign error     = (state_q == StErr);

endmodule

// File: tb/tb_boot_loader.sv
// Directed and randomized self-checking bench for boot_loader.
module tb_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 256;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, mem_we, cpu_reset, done, error;
    logic [31:0] mem_addr, mem_wdata;

    always #5 clk = ~clk;

    boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_lat_q[$];
    logic [31:0] img[$];
    logic [7:0]  stream[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Capture every write strobe; a write may never coincide with a released CPU.
    always @(negedge clk) begin
        if (!reset && mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_lat_q.push_back(cyc - last_acc);
            check("we_while_cpu_released", {31'b0, cpu_reset}, 32'd1);
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit took = 1'b0;
        int n = 0;
        while (!took && n < 300) begin
            @(negedge clk);
            rx_data  = b;
            rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            took = rx_valid && rx_ready;
            if (took) last_acc = cyc;
            n++;
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
        check("byte_accepted", {31'b0, took}, 32'd1);
    endtask

    // Reference model: image -> stream, expected writes and final status.
    task automatic run_load(input string tag, input logic [31:0] count, input bit gaps,
                            input bit bad_csum);
        logic [7:0] x = 8'h00;
        bit legal = (count <= MAXW);
        bit ok_end;
        int exp_n;
        bit any_took = 1'b0;
        stream.delete();
        for (int i = 3; i >= 0; i--) stream.push_back(8'(count >> (8 * i)));
        if (legal) begin
            foreach (img[w]) for (int i = 3; i >= 0; i--) stream.push_back(8'(img[w] >> (8 * i)));
        end
        foreach (stream[i]) x ^= stream[i];
        if (CSUM && legal) stream.push_back(bad_csum ? ((x == 8'h00) ? 8'h01 : 8'h00) : x);
        ok_end = legal && !(CSUM && bad_csum);
        exp_n  = legal ? img.size() : 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_lat_q.delete();
        foreach (stream[i]) send_byte(stream[i], gaps);
        @(negedge clk);
        // Last byte was a data byte only when no checksum trailer and count > 0.
        if (!legal || CSUM || count == 0) begin
            check({tag, "_done_lat"}, {31'b0, done}, {31'b0, ok_end});
            check({tag, "_err_lat"}, {31'b0, error}, {31'b0, !ok_end});
        end else begin
            check({tag, "_done_early"}, {31'b0, done}, 32'd0);
        end
        repeat (3) @(negedge clk);
        check({tag, "_nwrites"}, wr_addr_q.size(), exp_n);
        for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], img[i]);
            check($sformatf("%s_lat%0d", tag, i), wr_lat_q[i], 32'd1);
        end
        check({tag, "_done"}, {31'b0, done}, {31'b0, ok_end});
        check({tag, "_error"}, {31'b0, error}, {31'b0, !ok_end});
        check({tag, "_cpu_reset"}, {31'b0, cpu_reset}, {31'b0, !ok_end});
        check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'h5A;
            #1 if (rx_ready) any_took = 1'b1;
        end
        rx_valid = 1'b0;
        check({tag, "_ignored"}, {31'b0, any_took}, 32'd0);
        check({tag, "_nwrites_after"}, wr_addr_q.size(), exp_n);
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        reset = 1'b0;

        img = '{32'h2408_0005, 32'h0000_0000};
        run_load("two_words", 32'd2, 1'b0, 1'b0);

        do_reset();
        img.delete();
        run_load("zero_count", 32'd0, 1'b0, 1'b0);

        do_reset();
        img.delete();
        run_load("too_big", 32'd257, 1'b0, 1'b0);

        do_reset();
        img = '{32'hDEAD_BEEF};
        run_load("gaps", 32'd1, 1'b1, 1'b0);

        // Reset in the middle of a data word, then a clean reload.
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("mid_mem_we", {31'b0, mem_we}, 32'd0);
        check("mid_mem_addr", mem_addr, BASE);
        check("mid_mem_wdata", mem_wdata, 32'd0);
        check("mid_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        img = '{32'hCAFE_F00D, 32'h1234_5678};
        run_load("reload", 32'd2, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            int cnt = $urandom_range(1, 6);
            do_reset();
            img.delete();
            for (int w = 0; w < cnt; w++) img.push_back($urandom);
            run_load($sformatf("rand%0d", k), 32'(cnt), 1'b1, 1'b0);
        end

        if (CSUM) begin
            do_reset();
            img = '{32'h1122_3344};
            run_load("csum_good", 32'd1, 1'b0, 1'b0);
            do_reset();
            run_load("csum_bad", 32'd1, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
